seg595_scan: RTL and testbench
==============================

// Module: seg595_scan
// PURPOSE
//  Parametrised multiplexed 7-segment driver for a 74HC595 display chain
//  (segment byte + digit-select byte). Scans DIGITS hex digits
//  continuously, with per-digit decimal point and blanking.
//  Display content arrives via a valid/ready update port and is committed
//  only at frame boundaries, so a frame never mixes old and new content.
//  The block sits between a value producer (counters, status) and the
//  board serial pins segdata/shclk/stclk.
// PARAMETERS
//  DIGITS  8   digits scanned per frame, 1..8 (select byte is one-hot, 8 bits)
//  DIV     512 clk cycles per tick, >=2; one tick = half a shclk period
//  SEG_AL  1   1: segment byte active-low (common anode); 0: bitwise inverted
// PORTS
//  clk        in   1          system clock; all logic on posedge clk
//  rst        in   1          asynchronous reset, active-high
//  upd_hex    in   4*DIGITS   nibble i = hex value of digit i
//  upd_dp     in   DIGITS     1 = decimal point lit on digit i
//  upd_blank  in   DIGITS     1 = digit i fully dark
//  upd_valid  in   1          update offered
//  upd_ready  out  1          update accepted on the clk where valid&ready
//  segdata    out  1          serial data to the 595 chain
//  shclk      out  1          595 shift clock; data is stable across its rise
//  stclk      out  1          595 storage/latch clock
//  frame_done out  1          1-clk pulse after the last digit of a frame is latched
// BEHAVIOUR
//  Reset (async): segdata=0, shclk=0, stclk=0, frame_done=0, upd_ready=1.
//   Divider=0, digit index=0, state=LOAD, pending empty. Active buffer:
//   all digits blanked (seg byte 8'hFF when SEG_AL=1).
//  Tick: divider counts 0..DIV-1 and wraps. tick=1 for one clk at DIV-1.
//   All FSM and pin updates happen only on tick clocks.
//  Segment encoding, SEG_AL=1: hex 0..F -> C0 F9 A4 B0 99 92 82 F8
//   80 90 88 83 C6 A1 86 8E. dp clears bit7. blank forces FF (dp ignored).
//   SEG_AL=0: invert the final byte.
//  Select byte: one-hot, bit i=1 for digit i. Word = {seg,sel}, 16 bits,
//   shifted MSB first.
//  FSM per digit:
//   LOAD: build the word for the current digit. If digit==0, commit the
//    pending buffer to the active buffer first. Takes 1 tick.
//   SHIFT: for each of 16 bits, tick A sets shclk=0 and segdata=bit;
//    tick B sets shclk=1. Total 32 ticks.
//   LATCH: stclk=1 and shclk=0 for 1 tick.
//   GAP: stclk=0 for 1 tick. Then digit++. On wrap DIGITS-1 -> 0,
//    pulse frame_done for one clk and return to LOAD.
//   Digit period = 35 ticks. Frame period = 35*DIGITS*DIV clk.
//  Update handshake: upd_ready = ~pending_full.
//   valid&ready captures hex/dp/blank into pending and sets pending_full.
//   The commit in LOAD of digit 0 clears pending_full; ready rises the
//    following clk.
//   Several updates within one frame: only one is held; later offers stall.
//   Commit and valid in the same clk: commit wins; the offer is not taken
//    (ready was 0).
//  Reset mid-frame: pins return to reset values immediately. The partial
//   shift is abandoned. The 595 outputs hold their last latched data until
//   the next LATCH.
// TESTING (DIGITS=4, DIV=4, SEG_AL=1)
//  Reset then idle: first frame shifts FF,01 / FF,02 / FF,04 / FF,08.
//   stclk rises 33 ticks after each LOAD. frame_done at clk 4*35*4.
//  Offer hex=4'h3210, dp=0, blank=0 mid-frame 0: ready drops. Frame 0 stays
//   blank. Frame 1 shifts C0,01 / F9,02 / A4,04 / B0,08. Ready returns
//   1 clk after commit.
//  dp=4'b0100, blank=4'b1000, hex=F..: digit2 seg 8E&7F=0E; digit3 FF.
//  Two back-to-back offers: first accepted, second held off until commit,
//   then displayed one frame later.
//  Assert rst during SHIFT bit 7 of digit 2: all outputs 0 async. After
//   release, scan restarts at digit 0 with a blank buffer.
//  Check shclk high period = 4 clk, segdata stable 4 clk before every
//   shclk rise, and stclk never high while shclk is high.

Source files
------------

// File: rtl/seg595_scan.sv
// seg595_scan: multiplexed 7-segment scanner for a 74HC595 chain.
// Each digit is sent as a 16-bit word {segment byte, one-hot select byte},
// MSB first, then latched. New display content is taken through a
// valid/ready port into a single pending slot and only becomes visible at
// the start of a frame, so a frame never shows a mix of old and new values.
module seg595_scan #(
   parameter int DIGITS = 8,
   parameter int DIV    = 512,
   parameter bit SEG_AL = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] upd_hex,
   input  logic [DIGITS-1:0]   upd_dp,
   input  logic [DIGITS-1:0]   upd_blank,
   input  logic                upd_valid,
   output logic                upd_ready,
   output logic                segdata,
   output logic                shclk,
   output logic                stclk,
   output logic                frame_done
);
   localparam int DW = $clog2(DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
   localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {LOAD, SHIFT, LATCH, GAP} state_t;
   state_t state, state_next;

   logic [DW-1:0]       div_cnt;
   logic                tick;
   logic [IW-1:0]       digit;
   logic [4:0]          bit_cnt;
   logic [15:0]         word;
   logic [4*DIGITS-1:0] act_hex, pend_hex, src_hex;
   logic [DIGITS-1:0]   act_dp, pend_dp, src_dp;
   logic [DIGITS-1:0]   act_blank, pend_blank, src_blank;
   logic                pend_full;
   logic                commit;
   logic [7:0]          seg_all [DIGITS];
   logic [7:0]          sel;

   // Segment byte in common-anode polarity, then flipped for common cathode.
   function automatic logic [7:0] seg_byte(input logic [3:0] h, input logic dp, input logic blank);
      logic [7:0] s;
      case (h)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      if (dp) s[7] = 1'b0;
      if (blank) s = 8'hFF;
      return SEG_AL ? s : ~s;
   endfunction

   assign tick      = (div_cnt == DIV_LAST);
   assign commit    = tick && (state == LOAD) && (digit == '0);
   assign upd_ready = ~pend_full;
   assign sel       = 8'd1 << digit;

   // Tick divider: one tick every DIV clocks, half a shift-clock period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) div_cnt <= '0;
      else     div_cnt <= tick ? '0 : div_cnt + DW'(1);
   end

   // Digit 0's word must already see content being committed on this tick.
   always_comb begin
      src_hex   = act_hex;
      src_dp    = act_dp;
      src_blank = act_blank;
      if (commit && pend_full) begin
         src_hex   = pend_hex;
         src_dp    = pend_dp;
         src_blank = pend_blank;
      end
   end

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      // Encoded segment byte for each digit of the source buffer.
      always_comb seg_all[gi] = seg_byte(src_hex[4*gi +: 4], src_dp[gi], src_blank[gi]);
   end

   // Pending slot capture and frame-boundary commit to the active buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_full  <= 1'b0;
         pend_hex   <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         act_hex    <= '0;
         act_dp     <= '0;
         act_blank  <= '1;
      end else if (commit && pend_full) begin
         act_hex    <= pend_hex;
         act_dp     <= pend_dp;
         act_blank  <= pend_blank;
         pend_full  <= 1'b0;
      end else if (upd_valid && upd_ready) begin
         pend_hex   <= upd_hex;
         pend_dp    <= upd_dp;
         pend_blank <= upd_blank;
         pend_full  <= 1'b1;
      end
   end

   // Scan state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_next;
   end

   // Next-state logic; the machine only moves on tick clocks.
   always_comb begin
      state_next = state;
      if (tick) begin
         case (state)
            LOAD:    state_next = SHIFT;
            SHIFT:   if (bit_cnt == 5'd31) state_next = LATCH;
            LATCH:   state_next = GAP;
            GAP:     state_next = LOAD;
            default: state_next = LOAD;
         endcase
      end
   end

   // Word load, serial shifting, latch strobe and digit/frame sequencing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit      <= '0;
         bit_cnt    <= '0;
         word       <= '0;
         segdata    <= 1'b0;
         shclk      <= 1'b0;
         stclk      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (tick) begin
            case (state)
               LOAD: begin
                  word    <= {seg_all[digit], sel};
                  bit_cnt <= '0;
               end
               SHIFT: begin
                  bit_cnt <= bit_cnt + 5'd1;
                  if (!bit_cnt[0]) begin
                     // even tick: present next bit (MSB first) with shclk low
                     shclk   <= 1'b0;
                     segdata <= word[~bit_cnt[4:1]];
                  end else begin
                     shclk   <= 1'b1;
                  end
               end
               LATCH: begin
                  stclk <= 1'b1;
                  shclk <= 1'b0;
               end
               GAP: begin
                  stclk <= 1'b0;
                  if (digit == DIGIT_LAST) begin
                     digit      <= '0;
                     frame_done <= 1'b1;
                  end else begin
                     digit      <= digit + IW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_seg595_scan.sv
// Bench for seg595_scan (DIGITS=4, DIV=4, SEG_AL=1): a position-in-frame
// model predicts every pin each cycle, and the shifted words are
// reassembled and checked against hand-computed values.
module tb_seg595_scan;
   localparam int DIGITS = 4;
   localparam int DIV    = 4;
   localparam int FT     = 35 * DIGITS;   // ticks per frame
   localparam logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] upd_hex = '0;
   logic [3:0]  upd_dp = '0;
   logic [3:0]  upd_blank = '0;
   logic        upd_valid = 1'b0;
   logic        upd_ready, segdata, shclk, stclk, frame_done;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   logic [15:0] words [$];

   // model state
   int          m_e = 0;
   logic        m_full = 1'b0;
   logic [15:0] m_pend_hex = '0, m_act_hex = '0;
   logic [3:0]  m_pend_dp = '0, m_act_dp = '0;
   logic [3:0]  m_pend_blank = '0, m_act_blank = 4'hF;

   seg595_scan #(.DIGITS(DIGITS), .DIV(DIV), .SEG_AL(1'b1)) dut (
      .clk(clk), .rst(rst), .upd_hex(upd_hex), .upd_dp(upd_dp), .upd_blank(upd_blank),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .segdata(segdata), .shclk(shclk),
      .stclk(stclk), .frame_done(frame_done));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_commit(input int e);
      return (e % DIV == 0) && (e / DIV >= 1) && (((e / DIV) - 1) % FT == 0);
   endfunction

   function automatic logic [15:0] exp_word(input int d);
      logic [7:0] s;
      if (m_act_blank[d]) s = 8'hFF;
      else begin
         s = FONT[m_act_hex[4*d +: 4]];
         if (m_act_dp[d]) s[7] = 1'b0;
      end
      return {s, 8'(1 << d)};
   endfunction

   // cycle counter since reset release
   initial forever begin
      @(posedge clk);
      if (rst) cyc = 0; else cyc++;
   end

   // behavioural model: elapsed clocks, pending slot and active frame content
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_e = 0; m_full = 1'b0;
         m_act_hex = '0; m_act_dp = '0; m_act_blank = 4'hF;
      end else begin
         if (is_commit(m_e + 1) && m_full) begin
            m_act_hex = m_pend_hex; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
            m_full = 1'b0;
         end else if (upd_valid && !m_full) begin
            m_pend_hex = upd_hex; m_pend_dp = upd_dp; m_pend_blank = upd_blank;
            m_full = 1'b1;
         end
         m_e = m_e + 1;
      end
   end

   // per-cycle compare of every output against the model
   initial begin
      int n, k, d, j;
      logic [15:0] w;
      logic e_sd, e_sh, e_st, e_fd;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_segdata", segdata, 0);
            check("rst_shclk", shclk, 0);
            check("rst_stclk", stclk, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_ready", upd_ready, 1);
         end else begin
            n = m_e / DIV;
            e_sd = 1'b0; e_sh = 1'b0; e_st = 1'b0;
            if (n >= 1) begin
               k = (n - 1) % 35;
               d = ((n - 1) / 35) % DIGITS;
               w = exp_word(d);
               if (k == 0) e_sd = (n == 1) ? 1'b0 : (((d + DIGITS - 1) % DIGITS) == 0);
               else if (k <= 32) begin
                  j = k - 1;
                  e_sh = (j % 2 == 1);
                  e_sd = w[15 - j / 2];
               end else begin
                  e_st = (k == 33);
                  e_sd = w[0];
               end
            end
            e_fd = (m_e % DIV == 0) && (n >= 1) && (((n - 1) % FT) == FT - 1);
            check("segdata", segdata, e_sd);
            check("shclk", shclk, e_sh);
            check("stclk", stclk, e_st);
            check("frame_done", frame_done, e_fd);
            check("upd_ready", upd_ready, !m_full);
         end
      end
   end

   // reassemble shifted words at each latch; pin timing relations
   initial begin
      logic [15:0] acc;
      int nb, hi, stab;
      logic p_sh, p_st, p_sd;
      acc = '0; nb = 0; hi = 0; stab = 0; p_sh = 0; p_st = 0; p_sd = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            acc = '0; nb = 0; hi = 0; stab = 0; p_sh = 0; p_st = 0; p_sd = 0;
         end else begin
            if (segdata != p_sd) stab = 1; else stab++;
            if (shclk && !p_sh) begin
               check("segdata_setup", (stab > DIV), 1);
               acc = {acc[14:0], segdata};
               nb++;
            end
            if (shclk) hi++;
            if (!shclk && p_sh) begin
               check("shclk_high_clks", hi, DIV);
               hi = 0;
            end
            check("stclk_and_shclk", stclk & shclk, 0);
            if (stclk && !p_st) begin
               check("bits_per_word", nb, 16);
               words.push_back(acc);
               $display("word %0d: seg=%h sel=%h at clk %0d", words.size() - 1, acc[15:8], acc[7:0], cyc);
               nb = 0;
            end
            p_sh = shclk; p_st = stclk; p_sd = segdata;
         end
      end
   end

   // offer an update and hold it until taken; returns the accepting clk
   task automatic offer(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl, output int at);
      at = -1;
      upd_hex = h; upd_dp = dp; upd_blank = bl; upd_valid = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (upd_ready) begin
            @(posedge clk); #1;
            at = cyc;
            break;
         end
      end
      upd_valid = 1'b0;
      if (at < 0) check("offer_timeout", 0, 1);
   endtask

   task automatic wait_fd(output int at);
      at = -1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (frame_done) begin at = cyc; break; end
      end
   endtask

   task automatic wait_words(input int cnt);
      for (int i = 0; i < 4000 && words.size() < cnt; i++) @(posedge clk);
      check("word_count", words.size(), cnt);
   endtask

   task automatic check_words(input int base, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
      logic [15:0] e [4];
      e = '{w0, w1, w2, w3};
      for (int i = 0; i < 4; i++) check($sformatf("word%0d", base + i), words[base + i], e[i]);
   endtask

   initial begin
      int t, at, base;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready_lit", upd_ready, 1);
      check("reset_segdata_lit", segdata, 0);
      @(negedge clk) rst = 1'b0;

      // first latch: LOAD at tick 1, stclk at tick 34
      t = -1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         if (stclk) begin t = cyc; break; end
      end
      check("first_stclk_clk", t, 136);

      // mid-frame-0 offer of 3210
      while (cyc < 200) begin @(posedge clk); #1; end
      offer(16'h3210, 4'b0000, 4'b0000, at);
      check("offer1_accept_clk", at, 201);
      @(negedge clk);
      check("ready_drop", upd_ready, 0);

      wait_fd(at);
      check("frame_done_clk", at, 560);
      t = -1;
      for (int i = 0; i < 100; i++) begin
         if (upd_ready) begin t = cyc; break; end
         @(posedge clk); #1;
      end
      check("ready_return_clk", t, 564);

      // back-to-back offers: second stalls until the next commit
      offer(16'h5F98, 4'b0100, 4'b1000, at);
      check("offerA_accept_clk", at, 565);
      offer(16'h4CB7, 4'b0001, 4'b0000, at);
      check("offerB_accept_clk", at, 1125);

      wait_words(16);
      check_words(0, 16'hFF01, 16'hFF02, 16'hFF04, 16'hFF08);
      check_words(4, 16'hC001, 16'hF902, 16'hA404, 16'hB008);
      check_words(8, 16'h8001, 16'h9002, 16'h0E04, 16'hFF08);
      check_words(12, 16'h7801, 16'h8302, 16'hC604, 16'h9908);

      // reset while shifting word bit 7 of digit 2 in frame 4
      wait_words(18);
      while (cyc < 2592) begin @(posedge clk); #1; end
      check("pre_rst_shclk", shclk, 0);
      #2 rst = 1'b1;
      #1;
      check("async_segdata", segdata, 0);
      check("async_shclk", shclk, 0);
      check("async_stclk", stclk, 0);
      check("async_ready", upd_ready, 1);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      base = words.size();
      wait_fd(at);
      check("frame_done_after_rst", at, 560);
      check("words_after_rst", words.size(), base + 4);
      check_words(base, 16'hFF01, 16'hFF02, 16'hFF04, 16'hFF08);

      repeat (10) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required finish before 400000");
      $fatal(1, "watchdog");
   end
endmodule
